// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 multiplexer with manual and scan modes and a valid/ready output slot.
// Optional even-parity output dout_par is enabled by defining MUX_PARITY_EN.
module mux_nto1_seq #(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic                  req,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      dout,
    output logic [SEL_W-1:0]      dout_ch,
    output logic                  dout_last,
    output logic                  sel_err
`ifdef MUX_PARITY_EN
    ,
    output logic                  dout_par
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   cnt, cnt_n;
    logic               slot_free;
    logic               load;
    logic [WIDTH-1:0]   ld_data;
    logic [SEL_W-1:0]   ld_ch;
    logic               ld_last;
    logic               ld_err;

    assign slot_free = !out_valid || out_ready;
    assign busy      = (state == SCAN) || (out_valid && !out_ready);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        ld_data = '0;
        ld_ch   = '0;
        ld_last = 1'b0;
        ld_err  = 1'b0;
        case (state)
            IDLE: begin
                if (req && slot_free) begin
                    load = 1'b1;
                    if (!mode) begin
                        ld_ch   = sel;
                        ld_last = 1'b1;
                        // Out-of-range selects yield a zero word rather than indexing past din.
                        if (int'(sel) >= CH)
                            ld_err = 1'b1;
                        else
                            ld_data = din[int'(sel)*WIDTH +: WIDTH];
                    end else begin
                        ld_data = din[WIDTH-1:0];
                        cnt_n   = SEL_W'(1);
                        state_n = SCAN;
                    end
                end
            end
            SCAN: begin
                if (slot_free) begin
                    load    = 1'b1;
                    ld_data = din[int'(cnt)*WIDTH +: WIDTH];
                    ld_ch   = cnt;
                    if (cnt == SEL_W'(CH-1)) begin
                        ld_last = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            dout_ch   <= '0;
            dout_last <= 1'b0;
            sel_err   <= 1'b0;
`ifdef MUX_PARITY_EN
            dout_par  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                out_valid <= 1'b1;
                dout      <= ld_data;
                dout_ch   <= ld_ch;
                dout_last <= ld_last;
                sel_err   <= ld_err;
`ifdef MUX_PARITY_EN
                dout_par  <= ^ld_data;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
